// File: rtl/mux_nt1_pipe.sv
// Registered N:1 selector with valid/ready handshake; explicit-select or round-robin grant.
// One output register stage, full throughput, holds its word while the consumer stalls.
module mux_nt1_pipe #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [WIDTH-1:0]  in_words [NUM_IN];
   logic [NUM_IN-1:0] grant;
   logic              grant_any;
   logic [SEL_W-1:0]  grant_idx;
   logic              load_en;
   int                idx;

   logic [WIDTH-1:0]  data_q, data_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              valid_q, valid_d;
   logic [SEL_W-1:0]  rr_q, rr_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
         assign in_words[gi] = in_data[gi*WIDTH +: WIDTH];
         assign grant[gi]    = grant_any && (grant_idx == SEL_W'(gi));
      end
   endgenerate

   assign load_en = !valid_q || out_ready;

   // in_ready must be low while rst is held, even though the cleared output register opens load_en
   assign in_ready = {NUM_IN{load_en && !rst}} & grant;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      if (!mode) begin
         if (int'(sel) < NUM_IN) begin
            if (in_valid[sel]) begin
               grant_any = 1'b1;
               grant_idx = sel;
            end
         end
      end else begin
         for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!grant_any && in_valid[SEL_W'(idx)]) begin
               grant_any = 1'b1;
               grant_idx = SEL_W'(idx);
            end
         end
      end
   end

   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      rr_d    = rr_q;
      if (load_en) begin
         if (grant_any) begin
            data_d  = in_words[grant_idx];
            sel_d   = grant_idx;
            valid_d = 1'b1;
            if (mode) begin
               rr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         rr_q    <= '0;
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
      end
   end

   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nt1_pipe.sv
// Directed and random checks for mux_nt1_pipe (WIDTH=32, NUM_IN=4).
module tb_mux_nt1_pipe;

   logic         clk = 1'b0;
   logic         rst;
   logic         mode;
   logic [1:0]   sel;
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_sel;
   logic         out_valid;
   logic         out_ready;

   int total = 0;
   int bad   = 0;

   mux_nt1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
      rst = 1'b0;
      #1;
      $display("reset released");
   endtask

   task automatic test_explicit();
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
      in_data = '0; in_data[64 +: 32] = 32'hDEADBEEF;
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL explicit_ready got=%b exp=0100", in_ready); end
      step();
      total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL explicit_data got=%h exp=deadbeef", out_data); end
      total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL explicit_sel got=%0d exp=2", out_sel); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL explicit_valid got=%b exp=1", out_valid); end
      $display("explicit: sel=%0d data=%h", out_sel, out_data);
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data[64 +: 32] = 32'h1000 + i;
         #1;
         total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready); end
         step();
         total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=deadbeef", i, out_data); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
      end
      out_ready = 1'b1; in_valid = 4'b0000;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
      total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_hold_data got=%h exp=deadbeef", out_data); end
      $display("back-pressure: word released");
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_seq [5];
      exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = 32'hA0 + c;
      #1;
      total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got=%b exp=0001", in_ready); end
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (out_sel !== exp_seq[i]) begin bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", i, out_sel, exp_seq[i]); end
         total++; if (out_data !== 32'hA0 + 32'(exp_seq[i])) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, out_data, 32'hA0 + 32'(exp_seq[i])); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, out_valid); end
         $display("rr: sel=%0d data=%h", out_sel, out_data);
      end
      in_valid = 4'b1001;
      #1;
      total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL rr_1001_ready0 got=%b exp=1000", in_ready); end
      step();
      total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL rr_1001_sel0 got=%0d exp=3", out_sel); end
      total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rr_1001_ready1 got=%b exp=0001", in_ready); end
      step();
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rr_1001_sel1 got=%0d exp=0", out_sel); end
      $display("rr sparse: sel=%0d", out_sel);
   endtask

   task automatic test_no_grant();
      mode = 1'b0; sel = 2'd1; in_valid = 4'b1101; out_ready = 1'b0;
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL nogrant_ready0 got=%b exp=0000", in_ready); end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nogrant_hold_valid got=%b exp=1", out_valid); end
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL nogrant_hold_sel got=%0d exp=0", out_sel); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL nogrant_ready1 got=%b exp=0000", in_ready); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nogrant_drop_valid got=%b exp=0", out_valid); end
      $display("no grant: out_valid=%b", out_valid);
   endtask

   task automatic test_reset_mid();
      mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b0;
      in_data[96 +: 32] = 32'h12345678;
      #1;
      total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL rstmid_pre_ready got=%b exp=1000", in_ready); end
      step();
      total++; if (out_data !== 32'h12345678) begin bad++; $display("FAIL rstmid_load got=%h exp=12345678", out_data); end
      #3;
      rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rstmid_sel got=%0d exp=0", out_sel); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rstmid_ready got=%b exp=0000", in_ready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_rrptr got=%b exp=0001", in_ready); end
      in_valid = 4'b0000;
      $display("mid-transfer reset done");
   endtask

   task automatic test_random();
      logic [33:0] sb_q [$];
      logic [33:0] exp_w;
      logic        m_valid;
      logic [1:0]  m_rr;
      logic        g_any;
      logic [1:0]  g;
      logic [1:0]  j;
      logic        load;
      logic [3:0]  exp_ready;
      m_valid = 1'b0;
      m_rr    = 2'd0;
      for (int c = 0; c < 300; c++) begin
         mode      = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int ch = 0; ch < 4; ch++) in_data[ch*32 +: 32] = $urandom;
         if (c >= 280) begin
            in_valid  = 4'b0000;
            out_ready = 1'b1;
         end
         #3;
         total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, m_valid); end
         if (m_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               total++; bad++; $display("FAIL rand_underflow c=%0d got=word exp=none", c);
            end else begin
               exp_w = sb_q.pop_front();
               total++; if (out_data !== exp_w[31:0]) begin bad++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, exp_w[31:0]); end
               total++; if (out_sel !== exp_w[33:32]) begin bad++; $display("FAIL rand_sel c=%0d got=%0d exp=%0d", c, out_sel, exp_w[33:32]); end
               $display("rand out: c=%0d sel=%0d data=%h", c, out_sel, out_data);
            end
         end
         g_any = 1'b0;
         g     = 2'd0;
         if (!mode) begin
            if (in_valid[sel]) begin g_any = 1'b1; g = sel; end
         end else begin
            for (int k = 0; k < 4; k++) begin
               j = m_rr + 2'(k);
               if (!g_any && in_valid[j]) begin g_any = 1'b1; g = j; end
            end
         end
         load      = !m_valid || out_ready;
         exp_ready = (load && g_any) ? (4'b0001 << g) : 4'b0000;
         total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready); end
         if (load) begin
            if (g_any) sb_q.push_back({g, in_data[g*32 +: 32]});
            m_valid = g_any;
            if (g_any && mode) m_rr = g + 2'd1;
         end
         step();
      end
      total++; if (sb_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", sb_q.size()); end
   endtask

   initial begin
      test_reset();
      test_explicit();
      test_back_pressure();
      test_round_robin();
      test_no_grant();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
